// File: rtl/bst_mem_driver.sv
`default_nettype none
// ============================================================================
// Module      : bst_mem_driver
// Description : Turns one bst_engine node read/write request at a time into a
//               single-beat AXI4 transaction toward the node RAM and returns
//               read data on a handshaked completion channel.
// Revision    : 1.0 - initial release
// ============================================================================
module bst_mem_driver #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
  parameter int RAM_ID_WIDTH   = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // engine request side
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
  output logic                      mem_rd_valid,
  input  logic                      mem_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      mem_error,
  // AXI write address
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [RAM_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [RAM_ID_WIDTH-1:0]   axi_awid,
  output logic [7:0]                axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  // AXI write data
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic [RAM_DATA_WIDTH-1:0] axi_wdata,
  output logic [RAM_STRB_WIDTH-1:0] axi_wstrb,
  output logic                      axi_wlast,
  // AXI write response
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic [RAM_ID_WIDTH-1:0]   axi_bid,
  input  logic [1:0]                axi_bresp,
  // AXI read address
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [RAM_ADDR_WIDTH-1:0] axi_araddr,
  output logic [RAM_ID_WIDTH-1:0]   axi_arid,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  // AXI read data
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [RAM_ID_WIDTH-1:0]   axi_rid,
  input  logic [1:0]                axi_rresp,
  input  logic [RAM_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RD_CPL  = 3'd5;

  localparam logic [2:0] AXSIZE = 3'($clog2(RAM_STRB_WIDTH));

  logic [2:0]                state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RAM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      arvalid_q, arvalid_d;
  logic                      bready_q, bready_d;
  logic                      rready_q, rready_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      ready_q, ready_d;
  logic                      error_q, error_d;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q & axi_awready;
  assign w_hs  = wvalid_q & axi_wready;

  // IDs and last flags from the RAM carry no information for single-beat,
  // single-ID traffic.
  logic unused_ok;
  assign unused_ok = ^{axi_bid, axi_rid, axi_rlast};

  // Next-state and next-output computation for the request sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    arvalid_d  = arvalid_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (ready_q && mem_valid) begin
          // Write wins when both type bits are set; a typeless request is
          // consumed and dropped.
          if (mem_wr) begin
            addr_d    = mem_addr;
            wdata_d   = mem_wr_data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end else if (mem_rd) begin
            addr_d    = mem_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid && bready_q) begin
          error_d = error_q | (axi_bresp != 2'b00);
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid && rready_q) begin
          rdata_d = axi_rdata;
          error_d = error_q | (axi_rresp != 2'b00);
          state_d = S_RD_CPL;
        end
      end
      S_RD_CPL: begin
        if (mem_rd_ready && rd_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bready_d   = (state_d == S_WR_RESP);
    rready_d   = (state_d == S_RD_DATA);
    rd_valid_d = (state_d == S_RD_CPL);
    // mem_ready reopens one cycle after returning to IDLE, never on the
    // cycle a request is taken.
    ready_d    = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  // State and registered-output flops, cleared asynchronously.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      arvalid_q  <= arvalid_d;
      bready_q   <= bready_d;
      rready_q   <= rready_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  assign mem_ready    = ready_q;
  assign mem_rd_valid = rd_valid_q;
  assign mem_rd_data  = rdata_q;
  assign mem_error    = error_q;

  assign axi_awvalid  = awvalid_q;
  assign axi_awaddr   = addr_q;
  assign axi_awid     = '0;
  assign axi_awlen    = 8'd0;
  assign axi_awsize   = AXSIZE;
  assign axi_awburst  = 2'b01;

  assign axi_wvalid   = wvalid_q;
  assign axi_wdata    = wdata_q;
  assign axi_wstrb    = '1;
  assign axi_wlast    = 1'b1;

  assign axi_bready   = bready_q;

  assign axi_arvalid  = arvalid_q;
  assign axi_araddr   = addr_q;
  assign axi_arid     = '0;
  assign axi_arlen    = 8'd0;
  assign axi_arsize   = AXSIZE;
  assign axi_arburst  = 2'b01;

  assign axi_rready   = rready_q;

endmodule
`default_nettype wire
